// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the dmem_arbiter and the single-ported data memory.
// The arbiter takes the slave view; the requesters plus the memory take the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req0;
  logic                  req1;
  logic                  req_we0;
  logic                  req_we1;
  logic [2:0]            req_funct3_0;
  logic [2:0]            req_funct3_1;
  logic [ADDR_WIDTH-1:0] req_addr0;
  logic [ADDR_WIDTH-1:0] req_addr1;
  logic [DATA_WIDTH-1:0] req_wdata0;
  logic [DATA_WIDTH-1:0] req_wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rsp_valid0;
  logic                  rsp_valid1;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  mem_wr_en;
  logic [2:0]            mem_funct3;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  req0, req1, req_we0, req_we1, req_funct3_0, req_funct3_1,
           req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rd_data,
    output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_rdata, rsp_err,
           mem_wr_en, mem_funct3, mem_addr, mem_wr_data
  );

  modport master (
    output req0, req1, req_we0, req_we1, req_funct3_0, req_funct3_1,
           req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rd_data,
    input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_rdata, rsp_err,
           mem_wr_en, mem_funct3, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory: grant, one access, registered response.
// Define DMEM_ARB_RR_EN for round-robin tie-break; default is fixed priority with port 0 winning.
//
// state  | meaning
// IDLE   | no access in flight, grants may be issued
// ACCESS | latched request drives the memory for one cycle
// RESP   | response strobe visible, grants may be issued back-to-back
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nxt;

  logic                  pick1;
  logic                  gnt0_c;
  logic                  gnt1_c;
  logic                  any_gnt;
  logic                  owner;
  logic                  last_gnt;

  logic                  sel_we;
  logic [2:0]            sel_f3;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  we_q;
  logic                  err_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  rsp_valid0_q;
  logic                  rsp_valid1_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~a[0];
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // pick1 only ever rises with a live req1, so no grant goes out without a request
`ifdef DMEM_ARB_RR_EN
  always_comb pick1 = bus.req1 & (~bus.req0 | ~last_gnt);
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
  always_comb pick1 = bus.req1 & ~bus.req0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    case (state)
      IDLE, RESP: begin
        gnt0_c    = rst_n & bus.req0 & ~pick1;
        gnt1_c    = rst_n & pick1;
        state_nxt = (gnt0_c | gnt1_c) ? ACCESS : IDLE;
      end
      ACCESS:  state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  assign any_gnt   = gnt0_c | gnt1_c;
  assign bus.gnt0  = gnt0_c;
  assign bus.gnt1  = gnt1_c;

  assign sel_we    = pick1 ? bus.req_we1      : bus.req_we0;
  assign sel_f3    = pick1 ? bus.req_funct3_1 : bus.req_funct3_0;
  assign sel_addr  = pick1 ? bus.req_addr1    : bus.req_addr0;
  assign sel_wdata = pick1 ? bus.req_wdata1   : bus.req_wdata0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (any_gnt) begin
      owner    <= pick1;
      last_gnt <= pick1;
      we_q     <= sel_we;
      err_q    <= ~is_legal(sel_we, sel_f3, sel_addr[1:0]);
      f3_q     <= sel_f3;
      addr_q   <= sel_addr;
      wdata_q  <= sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      if (state == ACCESS) begin
        rsp_rdata_q  <= (we_q | err_q) ? '0 : bus.mem_rd_data;
        rsp_err_q    <= err_q;
        rsp_valid0_q <= ~owner;
        rsp_valid1_q <= owner;
      end
    end
  end

  assign bus.rsp_valid0  = rsp_valid0_q;
  assign bus.rsp_valid1  = rsp_valid1_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;

  // address/width/data stay on the last latched request; only the write enable is state-gated
  assign bus.mem_wr_en   = (state == ACCESS) & we_q & ~err_q;
  assign bus.mem_funct3  = f3_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model behind it.
module tb_dmem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem [0:63];

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] b, h, r;
    b = w >> (8 * a);
    h = w >> (16 * a[1]);
    case (f3)
      3'b000:  r = {{24{b[7]}}, b[7:0]};
      3'b100:  r = {24'h0, b[7:0]};
      3'b001:  r = {{16{h[15]}}, h[15:0]};
      3'b101:  r = {16'h0, h[15:0]};
      3'b010:  r = w;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [2:0] f3,
                                              input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    case (f3)
      3'b000:  r[8*a +: 8] = d[7:0];
      3'b001:  r[16*a[1] +: 16] = d[15:0];
      3'b010:  r = d;
      default: r = old;
    endcase
    return r;
  endfunction

  assign bus.mem_rd_data = load_ext(mem[bus.mem_addr[7:2]], bus.mem_funct3, bus.mem_addr[1:0]);

  always @(posedge clk)
    if (bus.mem_wr_en)
      mem[bus.mem_addr[7:2]] <= store_merge(mem[bus.mem_addr[7:2]], bus.mem_funct3,
                                            bus.mem_addr[1:0], bus.mem_wr_data);

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%08h, want 0x%08h", name, id, act, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_wr;
  } vec_t;

  vec_t vt [17];

  task automatic clear_reqs();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic drive_req(input int port, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.req0 = 1'b1; bus.req_we0 = we; bus.req_funct3_0 = f3;
      bus.req_addr0 = addr; bus.req_wdata0 = wdata;
    end else begin
      bus.req1 = 1'b1; bus.req_we1 = we; bus.req_funct3_1 = f3;
      bus.req_addr1 = addr; bus.req_wdata1 = wdata;
    end
  endtask

  // wait (bounded) for the port's grant; returns at posedge+1 of the ACCESS cycle
  task automatic wait_grant(input int port, input int id);
    int waited = 0;
    #1;
    while (!(port == 0 ? bus.gnt0 : bus.gnt1) && waited < 8) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("gnt_own",   id, {31'h0, (port == 0 ? bus.gnt0 : bus.gnt1)}, 32'h1);
    chk("gnt_other", id, {31'h0, (port == 0 ? bus.gnt1 : bus.gnt0)}, 32'h0);
    @(posedge clk); #1;
    clear_reqs();
  endtask

  task automatic run_vec(input vec_t v, input int id);
    drive_req(v.port, v.we, v.f3, v.addr, v.wdata);
    wait_grant(v.port, id);
    chk("access_wr_en",  id, {31'h0, bus.mem_wr_en}, {31'h0, v.exp_wr});
    chk("access_no_gnt", id, {30'h0, bus.gnt0, bus.gnt1}, 32'h0);
    chk("access_no_rsp", id, {30'h0, bus.rsp_valid0, bus.rsp_valid1}, 32'h0);
    @(posedge clk); #1;
    chk("rsp_valid_own",   id, {31'h0, (v.port == 0 ? bus.rsp_valid0 : bus.rsp_valid1)}, 32'h1);
    chk("rsp_valid_other", id, {31'h0, (v.port == 0 ? bus.rsp_valid1 : bus.rsp_valid0)}, 32'h0);
    chk("rsp_rdata", id, bus.rsp_rdata, v.exp_rdata);
    chk("rsp_err",   id, {31'h0, bus.rsp_err}, {31'h0, v.exp_err});
    chk("resp_wr_en", id, {31'h0, bus.mem_wr_en}, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    int seq [4];
`ifdef DMEM_ARB_RR_EN
    seq = '{0, 1, 0, 1};
`else
    seq = '{0, 0, 0, 0};
`endif
    //          port we  f3      addr   wdata         rdata         err   wr
    vt[0]  = '{0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b1};
    vt[1]  = '{0, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vt[2]  = '{1, 1'b1, 3'b000, 32'h13, 32'h80,       32'h00000000, 1'b0, 1'b1};
    vt[3]  = '{1, 1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0};
    vt[4]  = '{1, 1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b0, 1'b0};
    vt[5]  = '{0, 1'b0, 3'b010, 32'h02, 32'h0,        32'h00000000, 1'b1, 1'b0};
    vt[6]  = '{0, 1'b1, 3'b001, 32'h05, 32'hAAAA,     32'h00000000, 1'b1, 1'b0};
    vt[7]  = '{0, 1'b0, 3'b010, 32'h04, 32'h0,        32'h11223344, 1'b0, 1'b0};
    vt[8]  = '{1, 1'b0, 3'b011, 32'h10, 32'h0,        32'h00000000, 1'b1, 1'b0};
    vt[9]  = '{1, 1'b1, 3'b100, 32'h10, 32'h55,       32'h00000000, 1'b1, 1'b0};
    vt[10] = '{1, 1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 1'b0};
    vt[11] = '{0, 1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF80AD, 1'b0, 1'b0};
    vt[12] = '{1, 1'b0, 3'b101, 32'h12, 32'h0,        32'h000080AD, 1'b0, 1'b0};
    vt[13] = '{0, 1'b0, 3'b101, 32'h11, 32'h0,        32'h00000000, 1'b1, 1'b0};
    vt[14] = '{0, 1'b1, 3'b001, 32'h06, 32'h1234,     32'h00000000, 1'b0, 1'b1};
    vt[15] = '{1, 1'b0, 3'b010, 32'h04, 32'h0,        32'h12343344, 1'b0, 1'b0};
    vt[16] = '{0, 1'b0, 3'b000, 32'h05, 32'h0,        32'h00000033, 1'b0, 1'b0};

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[1] = 32'h11223344;
    mem[8] = 32'hCAFEF00D;

    clear_reqs();
    bus.req_we0 = 1'b0; bus.req_funct3_0 = 3'b000; bus.req_addr0 = 32'h0; bus.req_wdata0 = 32'h0;
    bus.req_we1 = 1'b0; bus.req_funct3_1 = 3'b000; bus.req_addr1 = 32'h0; bus.req_wdata1 = 32'h0;

    @(negedge clk);
    chk("reset_gnt_rsp", 0, {27'h0, bus.gnt0, bus.gnt1, bus.rsp_valid0, bus.rsp_valid1, bus.rsp_err}, 32'h0);
    chk("reset_rdata",   0, bus.rsp_rdata, 32'h0);
    chk("reset_mem_ctl", 0, {28'h0, bus.mem_wr_en, bus.mem_funct3}, 32'h0);
    chk("reset_mem_addr", 0, bus.mem_addr, 32'h0);
    chk("reset_mem_wdata", 0, bus.mem_wr_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(vt[i], i);

    chk("mem_word04_final", 0, mem[1], 32'h12343344);

    // idle: nothing granted or strobed, last response data held
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_quiet", i, {27'h0, bus.gnt0, bus.gnt1, bus.rsp_valid0, bus.rsp_valid1, bus.mem_wr_en}, 32'h0);
      chk("idle_hold_rdata", i, bus.rsp_rdata, 32'h00000033);
    end

    // reset cutting the ACCESS cycle of a store
    drive_req(0, 1'b1, 3'b010, 32'h20, 32'h12345678);
    wait_grant(0, 100);
    chk("rst_pre_wr_en", 0, {31'h0, bus.mem_wr_en}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wr_en_drop", 0, {31'h0, bus.mem_wr_en}, 32'h0);
    chk("rst_mem_addr",   0, bus.mem_addr, 32'h0);
    chk("rst_rsp",        0, {29'h0, bus.rsp_valid0, bus.rsp_valid1, bus.rsp_err}, 32'h0);
    chk("rst_rdata",      0, bus.rsp_rdata, 32'h0);
    @(posedge clk); #1;
    chk("rst_no_rsp", 1, {30'h0, bus.rsp_valid0, bus.rsp_valid1}, 32'h0);
    chk("rst_mem_untouched", 0, mem[8], 32'hCAFEF00D);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", i, {30'h0, bus.rsp_valid0, bus.rsp_valid1}, 32'h0);
    end
    run_vec('{0, 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0}, 200);

    // contention from a fresh reset: grants every other cycle
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(0, 1'b0, 3'b010, 32'h10, 32'h0);
    drive_req(1, 1'b0, 3'b010, 32'h04, 32'h0);
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("cont_gnt0", c, {31'h0, bus.gnt0}, {31'h0, (c % 2 == 0) && (seq[c/2] == 0)});
      chk("cont_gnt1", c, {31'h0, bus.gnt1}, {31'h0, (c % 2 == 0) && (seq[c/2] == 1)});
      if (c == 7) clear_reqs();
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    chk("cont_drained", 0, {27'h0, bus.gnt0, bus.gnt1, bus.rsp_valid0, bus.rsp_valid1, bus.mem_wr_en}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported data memory.
- Shares the memory between port 0 (core load/store unit) and port 1 (auxiliary master: program loader / debug / DMA).
- Per request: accepts, issues one memory access, returns a registered response.
- Rejects misaligned or illegal byte/half/word (funct3) accesses with an error response, without touching memory.

Parameters:
- ADDR_WIDTH, 32, request and memory address width
- DATA_WIDTH, 32, data width; byte-lane logic assumes 32

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  request valid, held until gnt
- req_we0 / req_we1  in  1  1 = store, 0 = load
- req_funct3_0 / req_funct3_1  in  3  RISC-V width code (000 b, 001 h, 010 w, 100 bu, 101 hu)
- req_addr0 / req_addr1  in  ADDR_WIDTH  byte address
- req_wdata0 / req_wdata1  in  DATA_WIDTH  store data, right-aligned
- gnt0 / gnt1  out  1  request accepted this cycle (combinational, one-hot or zero)
- rsp_valid0 / rsp_valid1  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_WIDTH  load data, shared by both ports, qualified by rsp_validN
- rsp_err  out  1  misaligned/illegal flag, qualified by rsp_validN
- mem_wr_en  out  1  memory write enable
- mem_funct3  out  3  width code to memory
- mem_addr  out  ADDR_WIDTH  address to memory
- mem_wr_data  out  DATA_WIDTH  store data to memory
- mem_rd_data  in  DATA_WIDTH  combinational read data from memory, already extended per funct3

Behaviour:
- States: IDLE, ACCESS, RESP. Reset: IDLE, every output 0, owner = 0, last_gnt = 1.
- Grant:
  - Evaluated in IDLE and RESP.
  - Pick a winner among asserted reqN; assert its gntN combinationally.
  - At the clock edge, latch we/funct3/addr/wdata and owner, then go to ACCESS.
  - With no request: RESP -> IDLE, IDLE stays.
- Legality check at latch time. Legal:
  - funct3 000/100 any address
  - funct3 001/101 with addr[0] = 0
  - funct3 010 with addr[1:0] = 00
  - Stores: only 000/001/010 legal.
  - Everything else sets err_q.
- ACCESS (one cycle):
  - mem_addr / mem_funct3 / mem_wr_data driven from latched registers.
  - mem_wr_en = we_q & ~err_q.
  - At the edge: rsp_rdata <= (we_q | err_q) ? 0 : mem_rd_data; rsp_err <= err_q; rsp_valid<owner> <= 1. Go to RESP.
- RESP: rsp_validN high exactly one cycle. rsp_rdata/rsp_err hold until the next response.
- mem_wr_en is 0 in every state except ACCESS. mem_addr/funct3/wr_data hold last latched values (no glitch-to-zero).
- Latency: gnt at cycle T, rsp_valid at T+2. Back-to-back grant from RESP gives one access per 2 cycles.
- Requester must not drop reqN before gntN. Behaviour on violation is undefined, but the FSM never hangs: no grant is issued without a live req.
- At most one outstanding request in total. gntN is never asserted in ACCESS.
- Default arbitration is fixed priority: port 0 wins when both request.
- Reset mid-operation: async clear to IDLE. An in-flight write whose ACCESS cycle is cut by reset is not performed (mem_wr_en drops immediately). No rsp_valid is issued.

Optional Feature:
- Macro: DMEM_ARB_RR_EN
- Defined: round-robin. When both request, grant the port != last_gnt. last_gnt updates on every grant. After reset port 0 wins the first tie.
- Undefined: fixed priority, port 0 always wins. last_gnt is still kept but unused.

Test Plan:
- Single store/load: port0 sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> mem_wr_en high only in the ACCESS cycle; load rsp_valid0 at T+2 with rsp_rdata 0xDEADBEEF, rsp_err 0.
- Byte/half: port1 sb 0x13 data 0x80, then lb 0x13 and lbu 0x13 -> rsp_rdata 0xFFFFFF80 then 0x00000080; gnt1 only, rsp_valid1 only.
- Misaligned: port0 lw 0x02, then sh 0x05 -> rsp_err 1, rsp_rdata 0, mem_wr_en never asserted, memory unchanged at word 0x04.
- Contention: req0 and req1 held for 4 grants -> fixed priority grants 0,0,0,0 (port1 starved); with DMEM_ARB_RR_EN grants 0,1,0,1. Grants spaced 2 cycles apart.
- Reset mid-access: assert rst_n=0 during ACCESS of sw 0x20 data 0x12345678 -> outputs 0 same cycle, no rsp_valid; after release, lw 0x20 returns the prior contents.
- Idle/illegal funct3: request funct3 011 load and 100 store -> rsp_err 1, no write; with no requests, FSM stays IDLE and all gnt/rsp_valid stay 0 for 10 cycles.
